// File: rtl/coeff_calc_stream_if.sv
// Sample/result stream bundle for the regression coefficient engine.
// The master side feeds samples and consumes coefficients; the slave is the engine.
interface coeff_calc_stream_if #(
   parameter int W = 20
);
   logic                start;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] x_in;
   logic signed [W-1:0] y_in;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] b1;
   logic signed [W-1:0] b0;
   logic                err;
   logic                busy;

   modport master (
      output start, in_valid, x_in, y_in, out_ready,
      input  in_ready, out_valid, b1, b0, err, busy
   );

   modport slave (
      input  start, in_valid, x_in, y_in, out_ready,
      output in_ready, out_valid, b1, b0, err, busy
   );
endinterface

// File: rtl/coeff_calc_stream.sv
// Streaming least-squares slope/intercept engine over N signed fixed-point (x, y) pairs.
// One restoring divider is shared by the slope and intercept divisions.
//
// state  | meaning
// IDLE   | waiting for start; last result held on b0/b1/err
// ACCUM  | accepting samples, building Sx, Sy, Sxx, Sxy
// MUL    | forming num1/den1, flagging degenerate data
// DIV1   | |num1|<<FRAC / den1, one quotient bit per cycle
// CALC0  | saturate b1, form num0 = Sy - (b1*Sx)>>>FRAC
// DIV0   | |num0| / N
// DONE   | publish result, hold until out_ready
module coeff_calc_stream #(
   parameter int W    = 20,
   parameter int FRAC = 10,
   parameter int N    = 150
) (
   input logic               clk,
   input logic               rst,
   coeff_calc_stream_if.slave bus
);
   localparam int CW  = $clog2(N + 1);
   localparam int DQ  = 2*W + 2*CW + FRAC + 2;
   localparam int AW  = W + CW;
   localparam int PW  = 2*W + CW;
   localparam int P0W = PW + 1;
   localparam int NW  = 2*W + 2*CW + 2;
   localparam int DCW = $clog2(DQ + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ACCUM, S_MUL, S_DIV1, S_CALC0, S_DIV0, S_DONE
   } state_t;

   state_t                state, state_nxt;
   logic signed [AW-1:0]  sx, sy;
   logic signed [PW-1:0]  sxx, sxy;
   logic [CW-1:0]         cnt;
   logic [DQ-1:0]         dvd, dvs, rem;
   logic [DCW-1:0]        div_cnt;
   logic                  neg1, neg0, err_int;
   logic signed [W-1:0]   b1_int, b0_q, b1_q;
   logic                  err_q, out_valid_q;

   logic                  xfer;
   logic signed [PW-1:0]  xx_c, xy_c, prod0_c;
   logic signed [NW-1:0]  num1_c, den1_c;
   logic [NW-1:0]         mag1_c;
   logic signed [W-1:0]   b1_c;
   logic signed [P0W-1:0] num0_c;
   logic [P0W-1:0]        mag0_c;
   logic [DQ:0]           rem_sh;
   logic                  rem_ge;
   logic [DQ-1:0]         rem_nxt;

   // Clamp a quotient magnitude with its sign into the signed W-bit range.
   function automatic logic signed [W-1:0] sat_w(input logic [DQ-1:0] mag, input logic neg);
      logic [DQ-1:0] lim;
      logic [DQ-1:0] m;
      lim = (DQ'(1) << (W-1)) - DQ'(!neg);
      m   = (mag > lim) ? lim : mag;
      return neg ? $signed(W'(DQ'(0) - m)) : $signed(W'(m));
   endfunction

   assign xfer    = bus.in_valid && (state == S_ACCUM);
   assign xx_c    = PW'(bus.x_in) * PW'(bus.x_in);
   assign xy_c    = PW'(bus.x_in) * PW'(bus.y_in);
   assign num1_c  = NW'(N) * NW'(sxy) - NW'(sx) * NW'(sy);
   assign den1_c  = NW'(N) * NW'(sxx) - NW'(sx) * NW'(sx);
   assign mag1_c  = num1_c[NW-1] ? $unsigned(-num1_c) : $unsigned(num1_c);
   assign b1_c    = sat_w(dvd, neg1);
   assign prod0_c = PW'(b1_c) * PW'(sx);
   assign num0_c  = P0W'(sy) - P0W'(prod0_c >>> FRAC);
   assign mag0_c  = num0_c[P0W-1] ? $unsigned(-num0_c) : $unsigned(num0_c);
   assign rem_sh  = {rem, dvd[DQ-1]};
   assign rem_ge  = (rem_sh >= {1'b0, dvs});
   assign rem_nxt = rem_ge ? DQ'(rem_sh - {1'b0, dvs}) : rem_sh[DQ-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_ACCUM;
         S_ACCUM: if (xfer && (cnt == CW'(N - 1))) state_nxt = S_MUL;
         S_MUL:   state_nxt = (den1_c == '0) ? S_DONE : S_DIV1;
         S_DIV1:  if (div_cnt == DCW'(1)) state_nxt = S_CALC0;
         S_CALC0: state_nxt = S_DIV0;
         S_DIV0:  if (div_cnt == DCW'(1)) state_nxt = S_DONE;
         S_DONE:  if (out_valid_q && bus.out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sx <= '0; sy <= '0; sxx <= '0; sxy <= '0; cnt <= '0;
         dvd <= '0; dvs <= '0; rem <= '0; div_cnt <= '0;
         neg1 <= 1'b0; neg0 <= 1'b0; err_int <= 1'b0; b1_int <= '0;
         b0_q <= '0; b1_q <= '0; err_q <= 1'b0; out_valid_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.start) begin
               sx <= '0; sy <= '0; sxx <= '0; sxy <= '0; cnt <= '0;
            end
            S_ACCUM: if (xfer) begin
               sx  <= sx + AW'(bus.x_in);
               sy  <= sy + AW'(bus.y_in);
               sxx <= sxx + xx_c;
               sxy <= sxy + xy_c;
               cnt <= cnt + CW'(1);
            end
            S_MUL: begin
               neg1    <= num1_c[NW-1];
               dvd     <= {mag1_c, {FRAC{1'b0}}};
               dvs     <= DQ'($unsigned(den1_c));
               rem     <= '0;
               div_cnt <= DCW'(DQ);
               err_int <= (den1_c == '0);
            end
            S_DIV1, S_DIV0: begin
               rem     <= rem_nxt;
               dvd     <= {dvd[DQ-2:0], rem_ge};
               div_cnt <= div_cnt - DCW'(1);
            end
            S_CALC0: begin
               b1_int  <= b1_c;
               neg0    <= num0_c[P0W-1];
               dvd     <= DQ'(mag0_c);
               dvs     <= DQ'(N);
               rem     <= '0;
               div_cnt <= DCW'(DQ);
            end
            S_DONE: begin
               // Results move to the outputs only here so the previous run stays visible until now.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  err_q       <= err_int;
                  b1_q        <= err_int ? '0 : b1_int;
                  b0_q        <= err_int ? '0 : sat_w(dvd, neg0);
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_ACCUM);
   assign bus.busy      = (state != S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.b0        = b0_q;
   assign bus.b1        = b1_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_coeff_calc_stream.sv
// Directed bench for coeff_calc_stream: one N=150 and one N=4 instance share stimulus,
// sel picks which one is started and observed.
module tb_coeff_calc_stream;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic               sel = 1'b0;
   logic               start_d = 1'b0;
   logic               in_valid = 1'b0;
   logic               out_ready = 1'b0;
   logic signed [19:0] x_d = '0;
   logic signed [19:0] y_d = '0;

   int n_checks = 0;
   int n_fail   = 0;

   coeff_calc_stream_if #(.W(20)) if_a ();
   coeff_calc_stream_if #(.W(20)) if_b ();

   assign if_a.start     = start_d & ~sel;
   assign if_a.in_valid  = in_valid & ~sel;
   assign if_a.out_ready = out_ready & ~sel;
   assign if_a.x_in      = x_d;
   assign if_a.y_in      = y_d;
   assign if_b.start     = start_d & sel;
   assign if_b.in_valid  = in_valid & sel;
   assign if_b.out_ready = out_ready & sel;
   assign if_b.x_in      = x_d;
   assign if_b.y_in      = y_d;

   coeff_calc_stream #(.W(20), .FRAC(10), .N(150)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   coeff_calc_stream #(.W(20), .FRAC(10), .N(4))   dut_b (.clk(clk), .rst(rst), .bus(if_b));

   logic               o_in_ready, o_out_valid, o_busy, o_err;
   logic signed [19:0] o_b0, o_b1;
   assign o_in_ready  = sel ? if_b.in_ready  : if_a.in_ready;
   assign o_out_valid = sel ? if_b.out_valid : if_a.out_valid;
   assign o_busy      = sel ? if_b.busy      : if_a.busy;
   assign o_err       = sel ? if_b.err       : if_a.err;
   assign o_b0        = sel ? if_b.b0        : if_a.b0;
   assign o_b1        = sel ? if_b.b1        : if_a.b1;

   task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start_d = 1'b1;
      tick();
      start_d = 1'b0;
   endtask

   task automatic send(input int x, input int y);
      int g;
      g = 0;
      x_d = 20'(x);
      y_d = 20'(y);
      in_valid = 1'b1;
      while (!o_in_ready && g < 100) begin
         tick();
         g++;
      end
      if (g >= 100) check("send_timeout", g, 0);
      else tick();
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!o_out_valid && lat < 400) begin
         tick();
         lat++;
      end
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run4(input int x0, input int x1, input int x2, input int x3,
                       input int y0, input int y1, input int y2, input int y3, output int lat);
      do_start();
      send(x0, y0);
      send(x1, y1);
      send(x2, y2);
      send(x3, y3);
      in_valid = 1'b0;
      wait_out(lat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int extra;
      int unstable;
      int gap;
      int xs[4];
      int ys[4];

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", o_in_ready, 0);
      check("rst_out_valid", o_out_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_err", o_err, 0);
      check("rst_b0", o_b0, 0);
      check("rst_b1", o_b1, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Ideal line y = 2x + 3 on the N=150 instance.
      do_start();
      check("start_to_ready", o_in_ready, 1);
      for (int i = 0; i < 150; i++) send(i * 1024, (2 * i + 3) * 1024);
      in_valid = 1'b0;
      check("ready_drop", o_in_ready, 0);
      wait_out(lat);
      check("ideal_latency", lat, 139);
      check("ideal_b1", o_b1, 2048);
      check("ideal_b0", o_b0, 3072);
      check("ideal_err", o_err, 0);
      accept();
      check("ideal_valid_clr", o_out_valid, 0);
      check("ideal_idle", o_busy, 0);
      tick();
      check("ideal_b1_held", o_b1, 2048);

      // Abort after 70 samples with an asynchronous reset.
      do_start();
      for (int i = 0; i < 70; i++) send(i * 1024, (2 * i + 3) * 1024);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("abort_in_ready", o_in_ready, 0);
      check("abort_busy", o_busy, 0);
      check("abort_out_valid", o_out_valid, 0);
      check("abort_b1", o_b1, 0);
      check("abort_b0", o_b0, 0);
      check("abort_err", o_err, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      do_start();
      for (int i = 0; i < 150; i++) send(i * 1024, (2 * i + 3) * 1024);
      in_valid = 1'b0;
      wait_out(lat);
      check("rerun_b1", o_b1, 2048);
      check("rerun_b0", o_b0, 3072);
      accept();

      // Negative slope on N=4 with gaps, backpressure and ignored start pulses.
      sel = 1'b1;
      tick();
      xs = '{0, 1024, 2048, 3072};
      ys = '{8192, 6144, 4096, 2048};
      do_start();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b0;
         gap = $urandom_range(0, 2);
         repeat (gap) tick();
         if (i == 2) begin
            start_d = 1'b1;
            tick();
            start_d = 1'b0;
         end
         send(xs[i], ys[i]);
      end
      x_d = 20'(7 * 1024);
      y_d = 20'(1024);
      in_valid = 1'b1;
      extra = 0;
      lat = 0;
      while (!o_out_valid && lat < 400) begin
         if (o_in_ready) extra++;
         start_d = (lat == 10);
         tick();
         lat++;
      end
      start_d = 1'b0;
      in_valid = 1'b0;
      check("neg_extra_xfers", extra, 0);
      check("neg_latency", lat, 119);
      check("neg_b1", o_b1, -2048);
      check("neg_b0", o_b0, 8192);
      check("neg_err", o_err, 0);
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         start_d = (i == 5);
         tick();
         if (!o_out_valid || o_b1 !== -20'sd2048 || o_b0 !== 20'sd8192) unstable++;
      end
      start_d = 1'b0;
      check("neg_hold", unstable, 0);
      start_d = 1'b1;
      out_ready = 1'b1;
      tick();
      start_d = 1'b0;
      out_ready = 1'b0;
      check("done_start_valid", o_out_valid, 0);
      tick();
      check("done_start_busy", o_busy, 0);
      check("done_start_ready", o_in_ready, 0);

      // All x equal: zero denominator.
      run4(5120, 5120, 5120, 5120, 1024, 3072, -2048, 0, lat);
      check("degen_latency", lat, 2);
      check("degen_err", o_err, 1);
      check("degen_b1", o_b1, 0);
      check("degen_b0", o_b0, 0);
      accept();

      // Slope far beyond range clamps to the positive limit.
      run4(0, 0, 0, 1, 0, 0, 0, 524287, lat);
      check("sat_b1", o_b1, 524287);
      check("sat_b0", o_b0, 130944);
      check("sat_err", o_err, 0);
      accept();

      // Sub-LSB slope truncates toward zero.
      run4(0, 1024, 2048, 3072, 0, 0, 0, 1, lat);
      check("trunc_b1", o_b1, 0);
      check("trunc_b0", o_b0, 0);
      check("trunc_err", o_err, 0);
      accept();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
